// File: rtl/draw_crate.sv
// ---------------------------------------------------------------------------
// draw_crate
//   Overlays up to two 64x64 crate sprites on the VGA pixel stream.
//   The stream has no backpressure: one pixel enters and one pixel leaves
//   every clock, so there is no valid/ready handshake anywhere in this block.
//
//   Pipeline:
//     stage 1 : hit test + ROM address generation (address/address1 registered)
//     stage 2 : crate ROMs return rgb_pixel/rgb_pixel1 (registered in the ROM)
//     stage 3 : registered colour mux (blanking > crate 0 > crate 1 > bg)
//   Every *_out is the matching *_in delayed by exactly 3 clocks.
//
// Ports
//   clk60MHz                 pixel clock
//   rst                      synchronous active-high reset
//   hcount_in..rgb_in        incoming timing/RGB bus
//   xpos/ypos, xpos1/ypos1   crate 0 / crate 1 top-left corner
//   address, address1        crate ROM read addresses {y[5:0], x[5:0]}
//   rgb_pixel, rgb_pixel1    crate ROM data, valid one clock after address
//   hcount_out..rgb_out      outgoing timing/RGB bus
// ---------------------------------------------------------------------------
module draw_crate #(
    parameter int          SPRITE_W    = 64,
    parameter int          SPRITE_H    = 64,
    parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
    input  logic        clk60MHz,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [11:0] xpos1,
    input  logic [11:0] ypos1,
    output logic [11:0] address,
    output logic [11:0] address1,
    input  logic [11:0] rgb_pixel,
    input  logic [11:0] rgb_pixel1,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } bus_t;

    // Inclusive lower bound, exclusive upper bound. The upper bound is
    // computed in 13 bits so a position near 4095 cannot wrap to a small
    // value and produce a phantom hit at the left/top of the screen.
    function automatic logic in_span(input logic [11:0] c, input logic [11:0] p,
                                     input logic [12:0] len);
        return (c >= p) && ({1'b0, c} < ({1'b0, p} + len));
    endfunction

    localparam logic [12:0] LEN_X = 13'(SPRITE_W);
    localparam logic [12:0] LEN_Y = 13'(SPRITE_H);

    // Positions are frozen per frame: captured only on the vblnk rising edge.
    logic        r_vblnk_prev;
    logic [11:0] r_x0, r_y0, r_x1, r_y1;

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            r_vblnk_prev <= 1'b0;
            r_x0 <= '0;
            r_y0 <= '0;
            r_x1 <= '0;
            r_y1 <= '0;
        end else begin
            r_vblnk_prev <= vblnk_in;
            if (vblnk_in && !r_vblnk_prev) begin
                r_x0 <= xpos;
                r_y0 <= ypos;
                r_x1 <= xpos1;
                r_y1 <= ypos1;
            end
        end
    end

    // ---------------- stage 1: hit test and address ----------------
    logic [11:0] w_hc, w_vc;
    logic        w_hit0, w_hit1;
    logic [11:0] w_addr0, w_addr1;

    assign w_hc = {1'b0, hcount_in};
    assign w_vc = {1'b0, vcount_in};

    assign w_hit0 = in_span(w_hc, r_x0, LEN_X) && in_span(w_vc, r_y0, LEN_Y);
    assign w_hit1 = in_span(w_hc, r_x1, LEN_X) && in_span(w_vc, r_y1, LEN_Y);

    // Low 6 bits of (c - p) equal (c[5:0] - p[5:0]) mod 64.
    assign w_addr0 = w_hit0 ? {6'(w_vc[5:0] - r_y0[5:0]), 6'(w_hc[5:0] - r_x0[5:0])} : 12'h000;
    assign w_addr1 = w_hit1 ? {6'(w_vc[5:0] - r_y1[5:0]), 6'(w_hc[5:0] - r_x1[5:0])} : 12'h000;

    bus_t r_s1_bus, r_s2_bus, r_s3_bus;
    logic r_s1_hit0, r_s1_hit1, r_s2_hit0, r_s2_hit1;
    bus_t w_in_bus, w_s3_next;

    assign w_in_bus = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                        vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

    // ---------------- stage 3 mux ----------------
    always_comb begin
        w_s3_next = r_s2_bus;
        if (r_s2_bus.hblnk || r_s2_bus.vblnk) begin
            w_s3_next.rgb = r_s2_bus.rgb;
        end else if (r_s2_hit0 && (rgb_pixel != TRANSPARENT)) begin
            w_s3_next.rgb = rgb_pixel;
        end else if (r_s2_hit1 && (rgb_pixel1 != TRANSPARENT)) begin
            w_s3_next.rgb = rgb_pixel1;
        end
    end

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            address   <= '0;
            address1  <= '0;
            r_s1_bus  <= '0;
            r_s1_hit0 <= 1'b0;
            r_s1_hit1 <= 1'b0;
            r_s2_bus  <= '0;
            r_s2_hit0 <= 1'b0;
            r_s2_hit1 <= 1'b0;
            r_s3_bus  <= '0;
        end else begin
            address   <= w_addr0;
            address1  <= w_addr1;
            r_s1_bus  <= w_in_bus;
            r_s1_hit0 <= w_hit0;
            r_s1_hit1 <= w_hit1;
            r_s2_bus  <= r_s1_bus;
            r_s2_hit0 <= r_s1_hit0;
            r_s2_hit1 <= r_s1_hit1;
            r_s3_bus  <= w_s3_next;
        end
    end

    assign hcount_out = r_s3_bus.hcount;
    assign vcount_out = r_s3_bus.vcount;
    assign hsync_out  = r_s3_bus.hsync;
    assign vsync_out  = r_s3_bus.vsync;
    assign hblnk_out  = r_s3_bus.hblnk;
    assign vblnk_out  = r_s3_bus.vblnk;
    assign rgb_out    = r_s3_bus.rgb;

endmodule

// File: doc/draw_crate.md
Name: draw_crate

Overview:
- Overlay stage for up to two 64x64 crate sprites on the VGA pixel stream, clocked at 60 MHz.
- Takes the incoming timing/RGB bus and the crate positions, drives the two read addresses of the crate ROM, and receives the two registered ROM pixels one cycle later.
- Outputs the timing/RGB bus delayed by 3 cycles, with crate pixels mixed in.
- Sits between the background/previous draw stage and the next draw stage (or the VGA output).

Parameters:
- SPRITE_W, 64, sprite width in pixels. Must be 64: the ROM address format fixes it.
- SPRITE_H, 64, sprite height in pixels. Must be 64: the ROM address format fixes it.
- TRANSPARENT, 12'hF0F, colour key. A ROM pixel equal to this value is not drawn.

Ports:
- clk60MHz  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- hcount_in  in  11  horizontal pixel counter.
- vcount_in  in  11  vertical line counter.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- hblnk_in  in  1  horizontal blanking.
- vblnk_in  in  1  vertical blanking.
- rgb_in  in  12  background pixel.
- xpos  in  12  crate 0 top-left x.
- ypos  in  12  crate 0 top-left y.
- xpos1  in  12  crate 1 top-left x.
- ypos1  in  12  crate 1 top-left y.
- address  out  12  crate 0 ROM address, {y[5:0], x[5:0]}.
- address1  out  12  crate 1 ROM address, {y[5:0], x[5:0]}.
- rgb_pixel  in  12  crate 0 ROM data; valid 1 cycle after address.
- rgb_pixel1  in  12  crate 1 ROM data; valid 1 cycle after address1.
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out  11/11/1/1/1/1/12  delayed bus.

Behaviour:
- Clocking and reset: one clock domain, clk60MHz. Reset is synchronous, active-high.
  - In the cycle after rst is sampled high, every output and internal register is 0. This includes address, address1, the latched positions and all pipeline stages.
  - Reset asserted mid-frame flushes the pipeline. Outputs hold 0 while rst is high.
  - Normal output resumes 3 cycles after rst falls. Latched positions stay 0 until the next vblnk rising edge.
- Position latch:
  - xpos/ypos/xpos1/ypos1 are captured into internal registers only on the rising edge of vblnk_in. This is detected against a registered copy of vblnk_in.
  - Mid-frame position changes have no effect until the next frame, so there is no tearing.
- Stage 1 (cycle N+1):
  - Hit test for each crate k, computed in 12-bit unsigned with hcount/vcount zero-extended: hit_k = (hc >= X_k) and (hc < X_k+64) and (vc >= Y_k) and (vc < Y_k+64).
  - Addresses: address = {(vc-Y_0)[5:0], (hc-X_0)[5:0]}, registered. address1 is formed the same way from crate 1.
  - When not hit, the address is 0.
  - The bus and the hit flags are registered alongside.
  - X_k+64 is evaluated in 13 bits, so positions near 4095 do not wrap. A crate partly off-screen is simply clipped.
- Stage 2 (cycle N+2): the ROM returns rgb_pixel/rgb_pixel1. The bus and hit flags are delayed one more register.
- Stage 3 (cycle N+3): registered output mux.
  - If hblnk or vblnk is set in the delayed bus: rgb_out = delayed rgb_in. Crates are never drawn in blanking.
  - Else if hit_0 and rgb_pixel != TRANSPARENT: rgb_out = rgb_pixel.
  - Else if hit_1 and rgb_pixel1 != TRANSPARENT: rgb_out = rgb_pixel1.
  - Else: rgb_out = delayed rgb_in.
  - Crate 0 has priority over crate 1 where they overlap. A transparent crate-0 pixel shows crate 1 beneath it.
- Latency: every *_out is exactly *_in delayed by 3 cycles. The sync, blank and count relationships are preserved bit-exactly.

Test Plan:
- Reset: assert rst for 2 cycles mid-line -> all outputs 0 on the following cycle. After release, hcount_out = hcount_in three cycles earlier.
- Single crate:
  - Stimulus: crate 0 latched at (100,50), ROM model returns 12'h123, crate 1 at (2000,2000).
  - At hcount=100, vcount=50: address=12'h000. Three cycles later rgb_out=12'h123.
  - At hcount=163, vcount=113: address=12'hFFF.
  - At hcount=164: rgb_out = background.
- Transparency and priority:
  - Stimulus: both crates at (200,200); ROM 0 returns TRANSPARENT, ROM 1 returns 12'h0A0 -> rgb_out=12'h0A0.
  - ROM 0 then returns 12'h00F -> rgb_out=12'h00F.
- Blanking: crate at (0,0) with hblnk_in=1 at hcount=10 -> rgb_out = rgb_in, address still 12'h00A.
- Position latch: change xpos from 100 to 300 at vcount=300 -> the crate stays at x=100 for the rest of the frame. It moves to x=300 after the next vblnk rising edge.
- Edge clip: crate at x=780 on an 800-wide line -> pixels drawn for hcount 780..799 with address[5:0]=0..19. No wrap to hcount 0..43.
